axi_lite_byte_master: RTL
=========================

Name: axi_lite_byte_master

Overview:
- AXI4-Lite initiator driven by a byte stream, so a host can read and write SoC memory-mapped space over UART without the CPU.
- Input bytes come from a UART receiver's byte output. Output bytes go to a UART transmitter's byte input.
- Connects as an additional master port on the SoC crossbar, alongside the CPU.
- Frames: write = 0x01, addr[4], data[4]; read = 0x02, addr[4]. Multi-byte fields are little-endian.

Parameters:
- AXI_ADDR_BW_p, 32, AXI address width. Lower AXI_ADDR_BW_p bits of the received 32-bit address are used.
- BYTE_TIMEOUT_p, 1_000_000, idle cycles allowed between command bytes before the partial frame is discarded.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_rx_valid  in  1  input byte valid
- i_rx_data  in  8  input byte
- o_rx_ready  out  1  input byte accepted when valid && ready
- o_tx_valid  out  1  output byte valid
- o_tx_data  out  8  output byte
- i_tx_ready  in  1  output byte accepted when valid && ready
- o_axi_awaddr  out  AXI_ADDR_BW_p  write address
- o_axi_awprot  out  3  constant 3'b000
- o_axi_awvalid  out  1  write address valid
- i_axi_awready  in  1  write address ready
- o_axi_wdata  out  32  write data
- o_axi_wstrb  out  4  constant 4'hF
- o_axi_wvalid  out  1  write data valid
- i_axi_wready  in  1  write data ready
- i_axi_bresp  in  2  write response
- i_axi_bvalid  in  1  write response valid
- o_axi_bready  out  1  write response ready
- o_axi_araddr  out  AXI_ADDR_BW_p  read address
- o_axi_arprot  out  3  constant 3'b000
- o_axi_arvalid  out  1  read address valid
- i_axi_arready  in  1  read address ready
- i_axi_rdata  in  32  read data
- i_axi_rresp  in  2  read response
- i_axi_rvalid  in  1  read data valid
- o_axi_rready  out  1  read data ready
- o_busy  out  1  high in every state except IDLE

Behaviour:
- Reset values (async, rst_n low): state IDLE. All AXI valid/ready outputs 0, o_tx_valid 0, o_busy 0, address/data registers 0. o_rx_ready is 1 (it decodes the IDLE state).
- States: IDLE, ADDR, WDATA, AXI_WR, AXI_B, AXI_AR, AXI_R, RESP.
- o_rx_ready is 1 only in IDLE, ADDR and WDATA.
- IDLE: on an accepted byte, 0x01 or 0x02 → ADDR; the byte counter clears and the opcode is latched.
  - Any other byte → RESP with one status byte 0xEE.
- ADDR: accepts 4 bytes, LSB first, 2-bit byte counter.
  - After the 4th byte: write → WDATA, read → AXI_AR.
- WDATA: accepts 4 bytes, LSB first, then → AXI_WR.
- AXI_WR:
  - awvalid and wvalid both assert the cycle after the last data byte is accepted.
  - Each drops independently the cycle after its own handshake. Handshakes may occur in either order or in the same cycle.
  - When both handshakes are done → AXI_B.
  - awaddr and wdata are stable while the corresponding valid is high.
- AXI_B: bready = 1. On bvalid, bresp is latched → RESP, sending 1 byte {6'b0, bresp}.
- AXI_AR: arvalid asserts the cycle after the 4th address byte; it holds until arready, then → AXI_R.
- AXI_R: rready = 1. On rvalid, rresp and rdata are latched → RESP, sending 5 bytes: {6'b0, rresp}, then rdata[7:0], [15:8], [23:16], [31:24].
- RESP:
  - o_tx_valid = 1 and o_tx_data is held stable until i_tx_ready.
  - The next byte is presented in the cycle after each handshake, with no gap.
  - After the last byte is accepted → IDLE.
- Inter-byte timeout:
  - In ADDR and WDATA, a counter increments each cycle without an accepted byte and clears on each accepted byte.
  - On reaching BYTE_TIMEOUT_p-1, the state → IDLE silently: no response, no AXI traffic.
  - Counter width is $clog2(BYTE_TIMEOUT_p).
- No timeout applies in AXI states; the block waits indefinitely for slave responses.
- Bytes arriving while not ready are backpressured, never dropped.
- Only one transaction is outstanding; there is no pipelining.
- Reset mid-operation: outputs return immediately to reset values. Any partially collected frame and pending response are discarded.

Test Plan:
- Write frame 01 00 00 00 00 EF BE AD DE, slave always ready, OKAY → one AW+W beat with awaddr=0x0, wdata=0xDEADBEEF, wstrb=F; tx byte 0x00.
- Read frame 02 04 00 00 00, slave returns rdata=0x12345678 OKAY → araddr=0x4; tx 00 78 56 34 12.
- Write with wready 3 cycles before awready, then a write with both handshakes in the same cycle → exactly one beat each, AXI_B entered only after both; bresp=SLVERR gives tx 0x02.
- Byte 0x55 in IDLE → tx 0xEE, no AXI valid asserted; the following valid read frame completes normally.
- Frame 01 00 00, then BYTE_TIMEOUT_p idle cycles → return to IDLE, no tx, no AXI traffic; the next frame decodes correctly.
- i_tx_ready toggled randomly during a read response, plus rst_n pulsed during AXI_AR → response bytes stable and in order; after reset all valids are 0 and o_rx_ready is 1.

Source files
------------

// File: rtl/axi_lite_byte_master.sv
// AXI4-Lite initiator controlled by a UART byte stream.
// Frames: write = 0x01, addr[4], data[4]; read = 0x02, addr[4]. Fields are little-endian.
// Responses: write -> {6'b0, bresp}; read -> {6'b0, rresp}, rdata LSB first.
// An unknown opcode -> 0xEE. A stalled partial frame is dropped silently after
// BYTE_TIMEOUT_p idle cycles.
module axi_lite_byte_master #(
  parameter int AXI_ADDR_BW_p  = 32,
  parameter int BYTE_TIMEOUT_p = 1_000_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // byte stream in (from UART receiver)
  input  logic                     i_rx_valid,
  input  logic [7:0]               i_rx_data,
  output logic                     o_rx_ready,
  // byte stream out (to UART transmitter)
  output logic                     o_tx_valid,
  output logic [7:0]               o_tx_data,
  input  logic                     i_tx_ready,
  // AXI4-Lite write address
  output logic [AXI_ADDR_BW_p-1:0] o_axi_awaddr,
  output logic [2:0]               o_axi_awprot,
  output logic                     o_axi_awvalid,
  input  logic                     i_axi_awready,
  // AXI4-Lite write data
  output logic [31:0]              o_axi_wdata,
  output logic [3:0]               o_axi_wstrb,
  output logic                     o_axi_wvalid,
  input  logic                     i_axi_wready,
  // AXI4-Lite write response
  input  logic [1:0]               i_axi_bresp,
  input  logic                     i_axi_bvalid,
  output logic                     o_axi_bready,
  // AXI4-Lite read address
  output logic [AXI_ADDR_BW_p-1:0] o_axi_araddr,
  output logic [2:0]               o_axi_arprot,
  output logic                     o_axi_arvalid,
  input  logic                     i_axi_arready,
  // AXI4-Lite read data
  input  logic [31:0]              i_axi_rdata,
  input  logic [1:0]               i_axi_rresp,
  input  logic                     i_axi_rvalid,
  output logic                     o_axi_rready,
  output logic                     o_busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, WDATA, AXI_WR, AXI_B, AXI_AR, AXI_R, RESP
  } state_e;

  localparam int TO_W = (BYTE_TIMEOUT_p > 1) ? $clog2(BYTE_TIMEOUT_p) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(BYTE_TIMEOUT_p - 1);

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
  localparam logic [7:0] BAD_CMD  = 8'hEE;

  state_e            state_q, state_d;
  logic              is_wr_q, is_wr_d;        // latched opcode: 1 = write
  logic [1:0]        cnt_q, cnt_d;            // byte index within a 4-byte field
  logic [TO_W-1:0]   to_q, to_d;              // idle cycles since last accepted byte
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       data_q, data_d;          // write data, later read data
  logic [1:0]        resp_q, resp_d;
  logic              err_q, err_d;            // response is the bad-command byte
  logic [2:0]        tx_idx_q, tx_idx_d;
  logic [2:0]        tx_last_q, tx_last_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;

  logic rx_hs, tx_hs, aw_fin, w_fin;

  // Handshake qualifiers and channel outputs decoded from registered state.
  assign o_rx_ready    = (state_q == IDLE) || (state_q == ADDR) || (state_q == WDATA);
  assign rx_hs         = i_rx_valid && o_rx_ready;
  assign o_tx_valid    = (state_q == RESP);
  assign tx_hs         = o_tx_valid && i_tx_ready;
  assign o_busy        = (state_q != IDLE);

  assign o_axi_awaddr  = addr_q[AXI_ADDR_BW_p-1:0];
  assign o_axi_araddr  = addr_q[AXI_ADDR_BW_p-1:0];
  assign o_axi_wdata   = data_q;
  assign o_axi_awprot  = 3'b000;
  assign o_axi_arprot  = 3'b000;
  assign o_axi_wstrb   = 4'hF;
  assign o_axi_awvalid = (state_q == AXI_WR) && !aw_done_q;
  assign o_axi_wvalid  = (state_q == AXI_WR) && !w_done_q;
  assign o_axi_bready  = (state_q == AXI_B);
  assign o_axi_arvalid = (state_q == AXI_AR);
  assign o_axi_rready  = (state_q == AXI_R);

  // A channel counts as finished once its handshake has happened, now or earlier.
  assign aw_fin = aw_done_q || (o_axi_awvalid && i_axi_awready);
  assign w_fin  = w_done_q  || (o_axi_wvalid  && i_axi_wready);

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      is_wr_q   <= 1'b0;
      cnt_q     <= '0;
      to_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      resp_q    <= '0;
      err_q     <= 1'b0;
      tx_idx_q  <= '0;
      tx_last_q <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_wr_q   <= is_wr_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      resp_q    <= resp_d;
      err_q     <= err_d;
      tx_idx_q  <= tx_idx_d;
      tx_last_q <= tx_last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Next-state logic: frame collection, AXI sequencing, response sequencing.
  always_comb begin
    // NOTE: every _d defaults to its _q first, so no path can infer a latch.
    state_d   = state_q;
    is_wr_d   = is_wr_q;
    cnt_d     = cnt_q;
    to_d      = to_q;
    addr_d    = addr_q;
    data_d    = data_q;
    resp_d    = resp_q;
    err_d     = err_q;
    tx_idx_d  = tx_idx_q;
    tx_last_d = tx_last_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    unique case (state_q)
      IDLE: begin
        if (rx_hs) begin
          if ((i_rx_data == OP_WRITE) || (i_rx_data == OP_READ)) begin
            is_wr_d = (i_rx_data == OP_WRITE);
            cnt_d   = '0;
            to_d    = '0;
            state_d = ADDR;
          end else begin
            err_d     = 1'b1;
            tx_idx_d  = '0;
            tx_last_d = '0;
            state_d   = RESP;
          end
        end
      end

      ADDR: begin
        if (rx_hs) begin
          addr_d = {i_rx_data, addr_q[31:8]};
          cnt_d  = cnt_q + 2'd1;
          to_d   = '0;
          if (cnt_q == 2'd3) state_d = is_wr_q ? WDATA : AXI_AR;
        end else if (to_q == TO_LAST) begin
          state_d = IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end

      WDATA: begin
        if (rx_hs) begin
          data_d = {i_rx_data, data_q[31:8]};
          cnt_d  = cnt_q + 2'd1;
          to_d   = '0;
          if (cnt_q == 2'd3) begin
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = AXI_WR;
          end
        end else if (to_q == TO_LAST) begin
          state_d = IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end

      AXI_WR: begin
        aw_done_d = aw_fin;
        w_done_d  = w_fin;
        if (aw_fin && w_fin) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = AXI_B;
        end
      end

      AXI_B: begin
        if (i_axi_bvalid) begin
          resp_d    = i_axi_bresp;
          err_d     = 1'b0;
          tx_idx_d  = '0;
          tx_last_d = '0;
          state_d   = RESP;
        end
      end

      AXI_AR: begin
        if (i_axi_arready) state_d = AXI_R;
      end

      AXI_R: begin
        if (i_axi_rvalid) begin
          resp_d    = i_axi_rresp;
          data_d    = i_axi_rdata;
          err_d     = 1'b0;
          tx_idx_d  = '0;
          tx_last_d = 3'd4;
          state_d   = RESP;
        end
      end

      RESP: begin
        if (tx_hs) begin
          if (tx_idx_q == tx_last_q) state_d = IDLE;
          else                       tx_idx_d = tx_idx_q + 3'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Response byte selection: status first, then read data LSB first.
  always_comb begin
    o_tx_data = 8'h00;
    case (tx_idx_q)
      3'd0:    o_tx_data = err_q ? BAD_CMD : {6'b0, resp_q};
      3'd1:    o_tx_data = data_q[7:0];
      3'd2:    o_tx_data = data_q[15:8];
      3'd3:    o_tx_data = data_q[23:16];
      3'd4:    o_tx_data = data_q[31:24];
      default: o_tx_data = 8'h00;
    endcase
  end

endmodule
